fifo_word_packer: RTL and testbench

Drains a synchronous FIFO (1-cycle registered read latency) and packs consecutive DATA_WIDTH entries into one PACK_RATIO-lane word, presented on a valid/ready stream. Sits directly downstream of the team's byte-wide synchronous FIFO and feeds wide consumers such as SPI-flash and SRAM writers. Supports a flush request that emits a partial word with an explicit byte count.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_word_packer.sv | 117 +++++++++++
 tb/tb_fifo_word_packer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO word packer: FSM state codes and the
// lane-counter width helper.
package fifo_pkg;

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    function automatic int lane_cnt_w(input int pack_ratio);
        return $clog2(pack_ratio) + 1;
    endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Drains a 1-cycle-latency synchronous FIFO and packs PACK_RATIO consecutive
// entries into one wide word on a valid/ready stream, with flush of partial words.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4
) (
    input  logic                                  iClk,
    input  logic                                  iRstN,
    input  logic                                  iFifoEmpty,
    output logic                                  oFifoRdEn,
    input  logic [DATA_WIDTH-1:0]                 iFifoRdData,
    input  logic                                  iFlush,
    output logic                                  oWordValid,
    input  logic                                  iWordReady,
    output logic [DATA_WIDTH*PACK_RATIO-1:0]      oWordData,
    output logic [lane_cnt_w(PACK_RATIO)-1:0]     oWordBytes
);

    localparam int CNT_W  = lane_cnt_w(PACK_RATIO);
    localparam int WORD_W = DATA_WIDTH * PACK_RATIO;
    localparam logic [CNT_W:0]   RATIO_EXT = (CNT_W + 1)'(PACK_RATIO);
    localparam logic [CNT_W-1:0] RATIO_CNT = CNT_W'(PACK_RATIO);

    logic [0:0]        state_r;
    logic [CNT_W-1:0]  lane_cnt_r;
    logic              rd_pend_r;
    logic              flush_pend_r;
    logic [WORD_W-1:0] word_r;
    logic [CNT_W-1:0]  bytes_r;
    logic              valid_r;

    logic [CNT_W:0]    lane_sum_s;
    logic              rd_en_s;
    logic              full_cap_s;
    logic              flush_emit_s;
    logic              flush_drop_s;
    logic              handshake_s;

    // Pop request and FSM transition conditions; the lane sum is one bit wider so it cannot wrap.
    always_comb begin
        lane_sum_s   = {1'b0, lane_cnt_r} + {{CNT_W{1'b0}}, rd_pend_r};
        rd_en_s      = (state_r == S_FILL) && !iFifoEmpty && !flush_pend_r
                       && (lane_sum_s < RATIO_EXT);
        full_cap_s   = (state_r == S_FILL) && rd_pend_r
                       && (lane_cnt_r == (RATIO_CNT - CNT_W'(1)));
        flush_emit_s = (state_r == S_FILL) && flush_pend_r && !rd_pend_r
                       && (lane_cnt_r != {CNT_W{1'b0}});
        flush_drop_s = (state_r == S_FILL) && flush_pend_r && !rd_pend_r
                       && (lane_cnt_r == {CNT_W{1'b0}});
        handshake_s  = valid_r && iWordReady;
    end

    // FSM, lane capture and output word registers.
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state_r      <= S_FILL;
            lane_cnt_r   <= {CNT_W{1'b0}};
            rd_pend_r    <= 1'b0;
            flush_pend_r <= 1'b0;
            word_r       <= {WORD_W{1'b0}};
            bytes_r      <= {CNT_W{1'b0}};
            valid_r      <= 1'b0;
        end else begin
            rd_pend_r <= rd_en_s;
            case (state_r)
                S_FILL: begin
                    if (rd_pend_r) begin
                        for (int i = 0; i < PACK_RATIO; i++) begin
                            if (lane_cnt_r == CNT_W'(i)) begin
                                word_r[i*DATA_WIDTH +: DATA_WIDTH] <= iFifoRdData;
                            end
                        end
                        lane_cnt_r <= lane_cnt_r + CNT_W'(1);
                    end
                    // Word completion swallows any flush raised while it was finishing.
                    if (full_cap_s) begin
                        state_r      <= S_HOLD;
                        valid_r      <= 1'b1;
                        bytes_r      <= RATIO_CNT;
                        flush_pend_r <= 1'b0;
                    end else if (flush_emit_s) begin
                        state_r      <= S_HOLD;
                        valid_r      <= 1'b1;
                        bytes_r      <= lane_cnt_r;
                        flush_pend_r <= 1'b0;
                    end else if (iFlush) begin
                        flush_pend_r <= 1'b1;
                    end else if (flush_drop_s) begin
                        flush_pend_r <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (iFlush) begin
                        flush_pend_r <= 1'b1;
                    end
                    if (handshake_s) begin
                        state_r    <= S_FILL;
                        valid_r    <= 1'b0;
                        lane_cnt_r <= {CNT_W{1'b0}};
                        word_r     <= {WORD_W{1'b0}};
                    end
                end
                default: begin
                    state_r <= S_FILL;
                end
            endcase
        end
    end

    assign oFifoRdEn  = rd_en_s;
    assign oWordValid = valid_r;
    assign oWordData  = word_r;
    assign oWordBytes = bytes_r;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: a byte FIFO model feeds the DUT and a
// queue of popped bytes predicts every presented word.
module tb_fifo_word_packer;

    localparam int DW = 8;
    localparam int PR = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        fifo_empty;
    logic        rd_en;
    logic [7:0]  rd_data = 8'h00;
    logic        flush;
    logic        valid;
    logic        ready;
    logic [31:0] wdata;
    logic [2:0]  wbytes;

    int errors = 0;
    int checks = 0;

    logic [7:0] fifo_mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         pop_cnt = 0;

    logic [7:0]  pend_q [$];
    logic        hold_r = 1'b0;
    logic [31:0] hold_data = 32'h0;
    logic [2:0]  hold_bytes = 3'h0;

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    fifo_word_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
        .iClk        (clk),
        .iRstN       (rstn),
        .iFifoEmpty  (fifo_empty),
        .oFifoRdEn   (rd_en),
        .iFifoRdData (rd_data),
        .iFlush      (flush),
        .oWordValid  (valid),
        .iWordReady  (ready),
        .oWordData   (wdata),
        .oWordBytes  (wbytes)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_pend();
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < pend_q.size() && i < PR; i++) w[i*8 +: 8] = pend_q[i];
        return w;
    endfunction

    // Byte FIFO with registered read data.
    always @(posedge clk) begin
        if (rd_en && !fifo_empty) begin
            rd_data <= fifo_mem[rd_ptr[7:0]];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    // Model: bytes popped since the last accepted word; reset discards them.
    always @(posedge clk) begin
        hold_r     <= rstn && valid && !ready;
        hold_data  <= wdata;
        hold_bytes <= wbytes;
        if (rd_en && !fifo_empty) pop_cnt <= pop_cnt + 1;
        if (!rstn) begin
            pend_q.delete();
        end else begin
            if (valid && ready) pend_q.delete();
            if (rd_en && !fifo_empty) pend_q.push_back(fifo_mem[rd_ptr[7:0]]);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (fifo_empty) chk("pop_on_empty", rd_en, 1'b0);
        if (valid) begin
            chk("pop_in_hold", rd_en, 1'b0);
            chk("model_bytes", wbytes, pend_q.size());
            chk("model_data", wdata, pack_pend());
        end
        if (hold_r) begin
            chk("hold_valid", valid, 1'b1);
            chk("hold_data", wdata, hold_data);
            chk("hold_bytes", wbytes, hold_bytes);
        end
    end

    task automatic push_seq(input logic [7:0] first, input logic [7:0] step, input int n);
        logic [7:0] b;
        b = first;
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr[7:0]] = b;
            wr_ptr = wr_ptr + 1;
            b = b + step;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_valid(input string name, input int n);
        int vc;
        vc = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (valid) vc++;
        end
        chk(name, 64'(vc), 64'd0);
    endtask

    // Entries already pushed at this negedge with ready=1; expects one word.
    task automatic run_word(input string name, input logic [31:0] exp_data,
                            input logic [2:0] exp_bytes, input int exp_lat, input int exp_pops);
        int first;
        int p0;
        logic [31:0] d;
        logic [2:0]  b;
        first = -1;
        p0 = pop_cnt;
        d = 32'h0;
        b = 3'h0;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (valid && first < 0) begin
                first = k;
                d = wdata;
                b = wbytes;
            end
            @(negedge clk);
        end
        chk({name, "_latency"}, 64'(first), 64'(exp_lat));
        chk({name, "_data"}, d, exp_data);
        chk({name, "_bytes"}, b, exp_bytes);
        chk({name, "_pops"}, 64'(pop_cnt - p0), 64'(exp_pops));
        chk({name, "_idle"}, valid, 1'b0);
    endtask

    initial begin
        int p0;
        int k;
        rstn  = 1'b0;
        ready = 1'b0;
        flush = 1'b0;
        cycles(2);
        chk("rst_valid", valid, 1'b0);
        chk("rst_data", wdata, 32'h0);
        chk("rst_bytes", wbytes, 3'h0);
        chk("rst_rden", rd_en, 1'b0);
        rstn  = 1'b1;
        ready = 1'b1;
        cycles(1);

        // Full word, best-case timing.
        push_seq(8'h11, 8'h11, 4);
        run_word("t1", 32'h44332211, 3'd4, 5, 4);

        // Back-pressure hold.
        ready = 1'b0;
        push_seq(8'h01, 8'h01, 6);
        k = 0;
        while (!valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t2_valid", valid, 1'b1);
        chk("t2_data", wdata, 32'h04030201);
        chk("t2_bytes", wbytes, 3'd4);
        p0 = pop_cnt;
        cycles(10);
        chk("t2_hold_pops", 64'(pop_cnt - p0), 64'd0);
        chk("t2_hold_valid", valid, 1'b1);
        chk("t2_hold_data", wdata, 32'h04030201);
        ready = 1'b1;
        cycles(1);
        count_valid("t2_no_partial", 8);
        chk("t2_tail_pops", 64'(pop_cnt - p0), 64'd2);

        // Flush of the two-lane remainder.
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        chk("t3_valid_early", valid, 1'b0);
        cycles(1);
        chk("t3_valid", valid, 1'b1);
        chk("t3_data", wdata, 32'h00000605);
        chk("t3_bytes", wbytes, 3'd2);
        cycles(1);
        chk("t3_done", valid, 1'b0);

        // Flush with nothing packed.
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        count_valid("t4_no_word", 10);
        push_seq(8'hB0, 8'h01, 4);
        run_word("t4", 32'hB3B2B1B0, 3'd4, 5, 4);

        // Flush coinciding with the last pop of a full word.
        p0 = pop_cnt;
        push_seq(8'hA0, 8'h01, 4);
        cycles(3);
        chk("t5_4th_pop", rd_en, 1'b1);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        chk("t5_valid_early", valid, 1'b0);
        cycles(1);
        chk("t5_valid", valid, 1'b1);
        chk("t5_data", wdata, 32'hA3A2A1A0);
        chk("t5_bytes", wbytes, 3'd4);
        count_valid("t5_no_empty_word", 10);
        chk("t5_pops", 64'(pop_cnt - p0), 64'd4);

        // Reset with a pop in flight after two captured lanes.
        push_seq(8'hC0, 8'h01, 3);
        cycles(3);
        rstn = 1'b0;
        cycles(1);
        chk("t6_valid", valid, 1'b0);
        chk("t6_data", wdata, 32'h0);
        chk("t6_bytes", wbytes, 3'h0);
        chk("t6_rden", rd_en, 1'b0);
        rstn = 1'b1;
        cycles(1);
        push_seq(8'hD0, 8'h01, 4);
        run_word("t6", 32'hD3D2D1D0, 3'd4, 5, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
